// File: rtl/cache_bus_arb_if.sv
// Burst bus bundle shared by the cache refill requesters and the system bus master port.
// The master modport drives the command side; the slave modport answers it.
interface cache_bus_arb_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteEnable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writeData;
    logic [BURST_W-1:0]  burstCount;
    logic                beginBurstTransfer;
    logic                waitRequest;
    logic [DATA_W-1:0]   readData;
    logic                readDataValid;

    modport master (
        output address, byteEnable, read, write, writeData, burstCount, beginBurstTransfer,
        input  waitRequest, readData, readDataValid
    );

    modport slave (
        input  address, byteEnable, read, write, writeData, burstCount,
        output waitRequest, readData, readDataValid
    );
endinterface

// File: rtl/cache_bus_arb.sv
// Two-requester burst arbiter: s0 (data cache) and s1 (instruction cache) share m0 for whole bursts.
// Define CACHE_BUS_ARB_RR_EN for round-robin arbitration; otherwise s0 has fixed priority.
module cache_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 5
) (
    input  logic                    clk,
    input  logic                    rest,
    cache_bus_arb_if.slave          s0,
    cache_bus_arb_if.slave          s1,
    cache_bus_arb_if.master         m0,
    output logic [1:0]              o_dbg_state,
    output logic                    o_dbg_grant
);
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RD_DATA = 2'd2, WR = 2'd3} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_grant, w_grant_nxt;
    logic               r_last_grant, w_last_grant_nxt;
    logic [BURST_W-1:0] r_remaining, w_remaining_nxt;

    logic                w_act0, w_act1, w_winner;
    logic                w_g_read, w_g_write;
    logic [ADDR_W-1:0]   w_g_address;
    logic [DATA_W/8-1:0] w_g_byteEnable;
    logic [DATA_W-1:0]   w_g_writeData;
    logic [BURST_W-1:0]  w_g_burstCount, w_beats;
    logic                w_rd_acc, w_wr_acc;

    assign w_act0 = s0.read | s0.write;
    assign w_act1 = s1.read | s1.write;

`ifdef CACHE_BUS_ARB_RR_EN
    assign w_winner = (w_act0 && w_act1) ? ~r_last_grant : ~w_act0;
`else
    assign w_winner = ~w_act0;
`endif

    assign w_g_read       = r_grant ? s1.read       : s0.read;
    assign w_g_write      = r_grant ? s1.write      : s0.write;
    assign w_g_address    = r_grant ? s1.address    : s0.address;
    assign w_g_byteEnable = r_grant ? s1.byteEnable : s0.byteEnable;
    assign w_g_writeData  = r_grant ? s1.writeData  : s0.writeData;
    assign w_g_burstCount = r_grant ? s1.burstCount : s0.burstCount;
    // A zero burst count is a single beat.
    assign w_beats = (w_g_burstCount == '0) ? BURST_W'(1) : w_g_burstCount;

    // Read wins when a requester raises both commands; the write is never issued.
    assign w_rd_acc = w_g_read & ~m0.waitRequest;
    assign w_wr_acc = w_g_write & ~w_g_read & ~m0.waitRequest;

    assign s0.readData  = m0.readData;
    assign s1.readData  = m0.readData;
    assign o_dbg_state  = r_state;
    assign o_dbg_grant  = r_grant;

    always_comb begin
        w_state_nxt           = r_state;
        w_grant_nxt           = r_grant;
        w_last_grant_nxt      = r_last_grant;
        w_remaining_nxt       = r_remaining;
        m0.address            = '0;
        m0.byteEnable         = '0;
        m0.writeData          = '0;
        m0.burstCount         = '0;
        m0.read               = 1'b0;
        m0.write              = 1'b0;
        m0.beginBurstTransfer = 1'b0;
        s0.waitRequest        = 1'b1;
        s1.waitRequest        = 1'b1;
        s0.readDataValid      = 1'b0;
        s1.readDataValid      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_act0 || w_act1) begin
                    w_grant_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_state_nxt      = CMD;
                end
            end
            CMD: begin
                m0.address            = w_g_address;
                m0.byteEnable         = w_g_byteEnable;
                m0.writeData          = w_g_writeData;
                m0.burstCount         = w_g_burstCount;
                m0.read               = w_g_read;
                m0.write              = w_g_write & ~w_g_read;
                m0.beginBurstTransfer = 1'b1;
                if (r_grant) s1.waitRequest = m0.waitRequest;
                else         s0.waitRequest = m0.waitRequest;
                if (w_rd_acc) begin
                    w_remaining_nxt = w_beats;
                    w_state_nxt     = RD_DATA;
                end else if (w_wr_acc) begin
                    w_remaining_nxt = w_beats - BURST_W'(1);
                    w_state_nxt     = (w_beats == BURST_W'(1)) ? IDLE : WR;
                end else if (!w_g_read && !w_g_write) begin
                    w_state_nxt = IDLE;
                end
            end
            RD_DATA: begin
                if (r_grant) s1.readDataValid = m0.readDataValid;
                else         s0.readDataValid = m0.readDataValid;
                if (m0.readDataValid) begin
                    w_remaining_nxt = r_remaining - BURST_W'(1);
                    if (r_remaining == BURST_W'(1)) w_state_nxt = IDLE;
                end
            end
            WR: begin
                m0.address    = w_g_address;
                m0.byteEnable = w_g_byteEnable;
                m0.writeData  = w_g_writeData;
                m0.burstCount = w_g_burstCount;
                m0.write      = w_g_write;
                if (r_grant) s1.waitRequest = m0.waitRequest;
                else         s0.waitRequest = m0.waitRequest;
                if (w_g_write && !m0.waitRequest) begin
                    w_remaining_nxt = r_remaining - BURST_W'(1);
                    if (r_remaining == BURST_W'(1)) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_remaining  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_remaining  <= w_remaining_nxt;
        end
    end
endmodule

// File: tb/tb_cache_bus_arb.sv
// Directed bench for cache_bus_arb: reset, read/write bursts, arbitration, edge cases.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_cache_bus_arb;
    localparam logic [1:0] S_IDLE = 2'd0, S_CMD = 2'd1, S_RD = 2'd2;

    logic       clk = 1'b0;
    logic       rest;
    logic [1:0] dbg_state;
    logic       dbg_grant;
    int         checks = 0;
    int         errors = 0;

    cache_bus_arb_if s0_if ();
    cache_bus_arb_if s1_if ();
    cache_bus_arb_if m0_if ();

    cache_bus_arb dut (
        .clk         (clk),
        .rest        (rest),
        .s0          (s0_if),
        .s1          (s1_if),
        .m0          (m0_if),
        .o_dbg_state (dbg_state),
        .o_dbg_grant (dbg_grant)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        s0_if.read = 0; s0_if.write = 0; s0_if.address = '0; s0_if.byteEnable = '1;
        s0_if.writeData = '0; s0_if.burstCount = 5'd1;
        s1_if.read = 0; s1_if.write = 0; s1_if.address = '0; s1_if.byteEnable = '1;
        s1_if.writeData = '0; s1_if.burstCount = 5'd1;
        m0_if.waitRequest = 1; m0_if.readData = '0; m0_if.readDataValid = 0;
    endtask

    task automatic test_reset();
        rest = 0;
        s0_if.read = 1; s0_if.address = 32'h1000; s0_if.burstCount = 5'd1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (m0_if.read !== 1'b0) begin errors++; $display("FAIL reset_m0_read got %0b exp 0", m0_if.read); end
        checks++; if ({s0_if.waitRequest, s1_if.waitRequest} !== 2'b11) begin errors++; $display("FAIL reset_wait got %b exp 11", {s0_if.waitRequest, s1_if.waitRequest}); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        rest = 1;
        @(negedge clk); #1;
        checks++; if (m0_if.read !== 1'b1 || m0_if.beginBurstTransfer !== 1'b1) begin errors++; $display("FAIL release_cmd got rd=%0b bbt=%0b exp 1 1", m0_if.read, m0_if.beginBurstTransfer); end
        checks++; if (m0_if.address !== 32'h1000) begin errors++; $display("FAIL release_addr got %0h exp 1000", m0_if.address); end
        m0_if.waitRequest = 0;
        @(negedge clk);
        s0_if.read = 0; m0_if.waitRequest = 1; m0_if.readDataValid = 1; m0_if.readData = 32'hCAFE;
        #1;
        checks++; if (s0_if.readDataValid !== 1'b1 || s0_if.readData !== 32'hCAFE || s1_if.readDataValid !== 1'b0) begin
            errors++; $display("FAIL reset_beat got v0=%0b d=%0h v1=%0b exp 1 cafe 0", s0_if.readDataValid, s0_if.readData, s1_if.readDataValid); end
        @(negedge clk);
        m0_if.readDataValid = 0; #1;
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_beat_idle got %0d exp 0", dbg_state); end
    endtask

    task automatic test_read_burst();
        logic [5:0] pat;
        int v0, v1, bbt, nd;
        pat = 6'b101101;
        v0 = 0; v1 = 0; bbt = 0; nd = 0;
        @(negedge clk);
        s1_if.read = 1; s1_if.address = 32'h2040; s1_if.burstCount = 5'd4; m0_if.waitRequest = 1;
        #1;
        checks++; if (s1_if.waitRequest !== 1'b1 || m0_if.read !== 1'b0) begin errors++; $display("FAIL rd_idle got w1=%0b rd=%0b exp 1 0", s1_if.waitRequest, m0_if.read); end
        @(negedge clk); #1;
        checks++; if (m0_if.read !== 1'b1 || m0_if.beginBurstTransfer !== 1'b1 || m0_if.burstCount !== 5'd4 || m0_if.address !== 32'h2040 || dbg_grant !== 1'b1) begin
            errors++; $display("FAIL rd_cmd got rd=%0b bbt=%0b bc=%0d a=%0h g=%0b exp 1 1 4 2040 1", m0_if.read, m0_if.beginBurstTransfer, m0_if.burstCount, m0_if.address, dbg_grant); end
        @(negedge clk);
        m0_if.waitRequest = 0; #1;
        checks++; if (s1_if.waitRequest !== 1'b0 || s0_if.waitRequest !== 1'b1) begin errors++; $display("FAIL rd_cmd_wait got w0=%0b w1=%0b exp 1 0", s0_if.waitRequest, s1_if.waitRequest); end
        @(negedge clk);
        s1_if.read = 0; m0_if.waitRequest = 1;
        for (int i = 5; i >= 0; i--) begin
            @(negedge clk);
            m0_if.readDataValid = pat[i]; m0_if.readData = 32'hD0 + 32'(i);
            #1;
            if (m0_if.beginBurstTransfer) bbt++;
            if (s0_if.readDataValid) v0++;
            if (s1_if.readDataValid) begin
                v1++;
                if (s1_if.readData !== 32'hD0 + 32'(i)) nd++;
            end
        end
        @(negedge clk);
        m0_if.readDataValid = 0; #1;
        checks++; if (v1 != 4 || v0 != 0) begin errors++; $display("FAIL rd_beats got s1=%0d s0=%0d exp 4 0", v1, v0); end
        checks++; if (nd != 0) begin errors++; $display("FAIL rd_data got %0d bad exp 0", nd); end
        checks++; if (bbt != 0) begin errors++; $display("FAIL rd_bbt_in_data got %0d exp 0", bbt); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rd_end_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_write_burst();
        int acc, bad_data, bad_wait, bbt;
        acc = 0; bad_data = 0; bad_wait = 0; bbt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            s0_if.write = (acc < 8); s0_if.burstCount = 5'd8; s0_if.writeData = 32'h100 + 32'(acc);
            m0_if.waitRequest = (c % 3 == 1);
            #1;
            if (s1_if.waitRequest !== 1'b1) bad_wait++;
            if (m0_if.write && !m0_if.waitRequest) begin
                if (m0_if.writeData !== 32'h100 + 32'(acc)) bad_data++;
                if (m0_if.beginBurstTransfer) bbt++;
                acc++;
            end
        end
        checks++; if (acc != 8) begin errors++; $display("FAIL wr_beats got %0d exp 8", acc); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL wr_data got %0d bad exp 0", bad_data); end
        checks++; if (bad_wait != 0) begin errors++; $display("FAIL wr_s1_wait got %0d low exp 0", bad_wait); end
        checks++; if (bbt != 1) begin errors++; $display("FAIL wr_bbt got %0d exp 1", bbt); end
        checks++; if (dbg_state !== S_IDLE || m0_if.write !== 1'b0) begin errors++; $display("FAIL wr_end got st=%0d wr=%0b exp 0 0", dbg_state, m0_if.write); end
    endtask

    task automatic test_arbitration();
        logic [2:0] exp_g;
`ifdef CACHE_BUS_ARB_RR_EN
        exp_g = 3'b010;
`else
        exp_g = 3'b000;
`endif
        @(negedge clk);
        rest = 0;
        @(negedge clk);
        rest = 1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            s0_if.read = 1; s0_if.address = 32'hA0; s1_if.read = 1; s1_if.address = 32'hB0;
            s0_if.burstCount = 5'd1; s1_if.burstCount = 5'd1; m0_if.waitRequest = 1;
            @(negedge clk); #1;
            checks++; if (dbg_state !== S_CMD || dbg_grant !== exp_g[r]) begin
                errors++; $display("FAIL arb_grant%0d got st=%0d g=%0b exp 1 %0b", r, dbg_state, dbg_grant, exp_g[r]); end
            checks++; if (m0_if.address !== (exp_g[r] ? 32'hB0 : 32'hA0)) begin
                errors++; $display("FAIL arb_addr%0d got %0h exp %0h", r, m0_if.address, exp_g[r] ? 32'hB0 : 32'hA0); end
            m0_if.waitRequest = 0;
            @(negedge clk);
            s0_if.read = 0; s1_if.read = 0; m0_if.waitRequest = 1; m0_if.readDataValid = 1; m0_if.readData = 32'(r);
            #1;
            checks++; if ({s1_if.readDataValid, s0_if.readDataValid} !== (exp_g[r] ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL arb_rdv%0d got %b exp %b", r, {s1_if.readDataValid, s0_if.readDataValid}, exp_g[r] ? 2'b10 : 2'b01); end
            @(negedge clk);
            m0_if.readDataValid = 0;
        end
    endtask

    task automatic test_edge_cases();
        @(negedge clk);
        s1_if.write = 1; s1_if.burstCount = 5'd0; s1_if.writeData = 32'h55; m0_if.waitRequest = 0;
        @(negedge clk); #1;
        checks++; if (m0_if.write !== 1'b1 || m0_if.writeData !== 32'h55 || s1_if.waitRequest !== 1'b0) begin
            errors++; $display("FAIL bc0_cmd got wr=%0b d=%0h w1=%0b exp 1 55 0", m0_if.write, m0_if.writeData, s1_if.waitRequest); end
        @(negedge clk);
        s1_if.write = 0; #1;
        checks++; if (dbg_state !== S_IDLE || m0_if.write !== 1'b0) begin errors++; $display("FAIL bc0_idle got st=%0d wr=%0b exp 0 0", dbg_state, m0_if.write); end
        s0_if.read = 1; s0_if.burstCount = 5'd2; m0_if.waitRequest = 1;
        @(negedge clk); #1;
        checks++; if (dbg_state !== S_CMD) begin errors++; $display("FAIL drop_cmd got %0d exp 1", dbg_state); end
        @(negedge clk);
        s0_if.read = 0; #1;
        checks++; if (m0_if.read !== 1'b0) begin errors++; $display("FAIL drop_m0_read got %0b exp 0", m0_if.read); end
        @(negedge clk);
        m0_if.waitRequest = 0; #1;
        checks++; if (dbg_state !== S_IDLE || m0_if.read !== 1'b0) begin errors++; $display("FAIL drop_idle got st=%0d rd=%0b exp 0 0", dbg_state, m0_if.read); end
        m0_if.readDataValid = 1; m0_if.readData = 32'hBAD; #1;
        checks++; if ({s0_if.readDataValid, s1_if.readDataValid} !== 2'b00) begin errors++; $display("FAIL stray_rdv got %b exp 00", {s0_if.readDataValid, s1_if.readDataValid}); end
        @(negedge clk);
        m0_if.readDataValid = 0;
        s1_if.read = 1; s1_if.burstCount = 5'd4; m0_if.waitRequest = 0;
        @(negedge clk);
        @(negedge clk);
        s1_if.read = 0; #1;
        checks++; if (dbg_state !== S_RD) begin errors++; $display("FAIL midrst_rd got %0d exp 2", dbg_state); end
        rest = 0;
        @(negedge clk);
        rest = 1; m0_if.readDataValid = 1; #1;
        checks++; if (dbg_state !== S_IDLE || {s0_if.readDataValid, s1_if.readDataValid} !== 2'b00) begin
            errors++; $display("FAIL midrst_drop got st=%0d rdv=%b exp 0 00", dbg_state, {s0_if.readDataValid, s1_if.readDataValid}); end
        @(negedge clk);
        m0_if.readDataValid = 0; #1;
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL midrst_idle got %0d exp 0", dbg_state); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_read_burst();
        test_write_burst();
        test_arbitration();
        test_edge_cases();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_bus_arb.md
# cache_bus_arb

Two-requester burst arbiter that shares the single external bus master port between the data cache refill path (s0) and the instruction cache refill path (s1). Each cache's bus-side master connects to one slave port; m0 drives the system bus. Grant is held for a whole burst, read or write, so beats from different requesters never interleave.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byteEnable is DATA_W/8
- BURST_W, 5, burstCount width (max burst 16 beats)

Ports:
- clk  in  1  clock, all logic on rising edge
- rest  in  1  reset, synchronous, active-low
- s0_/s1_address  in  ADDR_W  requester address
- s0_/s1_byteEnable  in  DATA_W/8  byte lanes
- s0_/s1_read, s0_/s1_write  in  1  command request
- s0_/s1_writeData  in  DATA_W  write beat data
- s0_/s1_burstCount  in  BURST_W  beats in burst (0 treated as 1)
- s0_/s1_waitRequest  out  1  stall to requester
- s0_/s1_readData  out  DATA_W  read beat data (m0_readData broadcast)
- s0_/s1_readDataValid  out  1  read beat valid, granted requester only
- m0_address, m0_byteEnable, m0_writeData, m0_burstCount  out  muxed from granted requester
- m0_read, m0_write  out  1  bus command
- m0_beginBurstTransfer  out  1  first command beat marker
- m0_waitRequest  in  1  bus stall
- m0_readData  in  DATA_W; m0_readDataValid  in  1

## Operation
- States: IDLE, CMD, RD_DATA, WR. Registers: state, grant (0=s0, 1=s1), remaining beat count (BURST_W), last-grant pointer.
- IDLE: requester is active if read|write. None active -> stay. Otherwise pick winner (see Configuration), grant<=winner, ->CMD. Both requesters see waitRequest=1.
- CMD: m0 command fields = granted requester's; m0_beginBurstTransfer=1. Granted waitRequest=m0_waitRequest; other=1.
  - read accepted (m0_read & !m0_waitRequest): remaining<=max(burstCount,1), ->RD_DATA.
  - write accepted: remaining<=max(burstCount,1)-1; if result 0 ->IDLE else ->WR.
  - read and write both high: read wins, write ignored.
  - both dropped before acceptance: ->IDLE, no bus transfer.
- RD_DATA: m0_read=m0_write=0; both waitRequest=1. Each m0_readDataValid forwarded to granted requester, remaining-1; beat with remaining==1 ->IDLE.
- WR: m0_write=granted write, beginBurstTransfer=0, granted waitRequest=m0_waitRequest. Each accepted beat remaining-1; remaining==1 on acceptance ->IDLE.
- m0_readDataValid outside RD_DATA is dropped (no requester sees it).
- Last-grant pointer updated to grant on IDLE->CMD.

## Timing
- Reset (rest=0 at edge): state=IDLE, grant=0, remaining=0, last-grant=1; m0_read/write/beginBurstTransfer=0, m0_address/byteEnable/writeData/burstCount=0; s0/s1_waitRequest=1, readDataValid=0. Reset mid-burst abandons it; later bus beats dropped.
- Arbitration latency: request seen in IDLE at cycle N -> m0 command valid at N+1.
- Read burst of B beats: bus busy until last beat; IDLE one cycle after, earliest next command 2 cycles after last beat.
- Write burst of B beats, zero wait: CMD+WR occupy B cycles, then one IDLE cycle.
- Outputs to m0 are combinational from registered grant/state and requester inputs; no combinational path from m0_waitRequest to m0 command.

## Configuration
- CACHE_BUS_ARB_RR_EN defined: round-robin; with both active, requester not equal to last-grant wins; single active wins.
- Undefined: fixed priority, s0 (data cache) always wins when active; last-grant maintained but unused.

## Test plan
- Reset: hold rest=0 with s0_read=1 -> m0_read=0, s0/s1_waitRequest=1; release -> m0_read=1 one cycle after first IDLE edge.
- s1 read, burstCount=4, bus 2-cycle wait then 4 valid beats -> s1_readDataValid exactly 4, s0_readDataValid 0, beginBurstTransfer only in CMD.
- s0 write burstCount=8 with m0_waitRequest toggling -> exactly 8 accepted beats on m0, s1 held waitRequest=1 throughout.
- s0,s1 read simultaneously, repeated 3 times: RR_EN -> grants s0,s1,s0; without -> s0,s0,s0.
- burstCount=0 write -> single beat, return to IDLE; s0 drops read in CMD before acceptance -> IDLE, no m0 beat completed.
- Stray m0_readDataValid while IDLE -> no readDataValid to either requester.
